sram_access_controller: RTL

SRAM_ACCESS_CONTROLLER -- requirements
Module: sram_access_controller

---
 rtl/sram_access_controller_pkg.sv | 16 +
 rtl/sram_access_controller_wait_counter.sv | 27 ++
 rtl/sram_access_controller.sv | 98 +++++++++
 3 files changed

// File: rtl/sram_access_controller_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM access controller.
package sram_access_controller_pkg;

   localparam int unsigned SRAM_AW           = 18;
   localparam int unsigned SRAM_DW           = 16;
   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
   localparam int unsigned WAIT_CNT_W        = 3;

   typedef enum logic [1:0] {
      StIdle,
      StLow,
      StHigh,
      StDone
   } state_e;

endpackage

// File: rtl/sram_access_controller_wait_counter.sv
// Phase timer: counts cycles inside one SRAM half-word phase.
module sram_wait_counter
   import sram_access_controller_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic done
);

   logic [WAIT_CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + 1'b1;
      end
   end

   assign done = (count_q == WAIT_CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_access_controller.sv
// Splits each 32-bit pipeline load/store into two 16-bit SRAM phases, stalling via ready.
module sram_access_controller
   import sram_access_controller_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n
);

   localparam int unsigned IDX_W = SRAM_AW - 1;

   state_e           state_q;
   logic             is_write_q;
   logic             req;
   logic             wait_done;
   logic             wait_clear;
   logic [IDX_W-1:0] word_idx;

   assign req      = rd_en | wr_en;
   // Addresses below BASE_ADDR or past the SRAM wrap silently.
   assign word_idx = IDX_W'((address - BASE_ADDR) >> 2);

   assign ready      = (state_q == StDone) || ((state_q == StIdle) && !req);
   assign wait_clear = !((state_q == StLow) || (state_q == StHigh)) || wait_done;

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(wait_clear),
      .done (wait_done)
   );

   // SRAM pins are set up one edge ahead so they are glitch-free for the whole phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         is_write_q  <= 1'b0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  state_q     <= StLow;
                  is_write_q  <= wr_en;
                  sram_addr   <= {word_idx, 1'b0};
                  sram_dq_out <= wr_en ? write_data[15:0] : '0;
                  sram_dq_oe  <= wr_en;
                  sram_we_n   <= ~wr_en;
               end
            end
            StLow: begin
               if (wait_done) begin
                  state_q     <= StHigh;
                  sram_addr   <= {word_idx, 1'b1};
                  sram_dq_out <= is_write_q ? write_data[31:16] : '0;
                  if (!is_write_q) read_data[15:0] <= sram_dq_in;
               end
            end
            StHigh: begin
               if (wait_done) begin
                  state_q     <= StDone;
                  sram_addr   <= '0;
                  sram_dq_out <= '0;
                  sram_dq_oe  <= 1'b0;
                  sram_we_n   <= 1'b1;
                  if (!is_write_q) read_data[31:16] <= sram_dq_in;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
